// File: rtl/seq_mult_hs.sv
// seq_mult_hs: sequential shift-add unsigned multiplier with valid/ready handshakes.
// One multiplier (A) bit is consumed per RUN cycle; the product is held in DONE
// until the consumer takes it.
// Optional build macro: SEQ_MULT_EARLY_TERM_EN -- leave RUN as soon as no set A
// bits remain, giving a data-dependent latency reported on out_cycles.
module seq_mult_hs #(
    parameter int unsigned  A_W = 8,
    parameter int unsigned  B_W = 8,
    localparam int unsigned P_W = A_W + B_W,
    localparam int unsigned CW  = $clog2(A_W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_p,
    output logic [CW-1:0]  out_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [A_W-1:0] a_sh_q, a_sh_d;
    logic [B_W-1:0] b_reg_q, b_reg_d;
    logic [P_W-1:0] acc_q, acc_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [P_W-1:0] out_p_q, out_p_d;
    logic [CW-1:0]  out_cycles_q, out_cycles_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [P_W-1:0] addend_c;
    logic [P_W-1:0] sum_c;
    logic           last_c;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_reg_d      = b_reg_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        out_p_d      = out_p_q;
        out_cycles_d = out_cycles_q;

        addend_c = a_sh_q[0] ? (P_W'(b_reg_q) << idx_q) : '0;
        sum_c    = acc_q + addend_c;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_c   = (idx_q == CW'(A_W - 1)) || ((a_sh_q >> 1) == '0);
`else
        last_c   = (idx_q == CW'(A_W - 1));
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = S_RUN;
                    a_sh_d  = in_a;
                    b_reg_d = in_b;
                    acc_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                acc_d  = sum_c;
                a_sh_d = a_sh_q >> 1;
                idx_d  = idx_q + CW'(1);
                cnt_d  = cnt_q + CW'(1);
                if (last_c) begin
                    state_d      = S_DONE;
                    out_p_d      = sum_c;
                    out_cycles_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_reg_q      <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            out_p_q      <= '0;
            out_cycles_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_reg_q      <= b_reg_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            out_p_q      <= out_p_d;
            out_cycles_q <= out_cycles_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_p      = out_p_q;
    assign out_cycles = out_cycles_q;

endmodule
